sram_like_arbiter: RTL and testbench



---
 rtl/sram_like_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Two-into-one arbiter for the SRAM-like bus: round-robin grant with locking while
// a request waits for addr_ok, plus an in-order ownership FIFO to route data_ok back.
module sram_like_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    SrcInst = 1'b0,
    SrcData = 1'b1
  } src_e;

  // Arbitration state
  src_e                 last_q, last_d;
  logic                 lock_q, lock_d;
  src_e                 lock_owner_q, lock_owner_d;

  // Ownership FIFO state
  logic [MAX_OUTSTANDING-1:0] own_q, own_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 owner_req;
  logic                 gnt_valid;
  src_e                 gnt;
  logic                 accept;
  logic                 pop;
  src_e                 head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (cnt_q == CntFull);
  assign fifo_empty = (cnt_q == '0);
  assign owner_req  = (lock_owner_q == SrcData) ? data_req : inst_req;
  assign head       = src_e'(own_q[rd_ptr_q]);

  // A full FIFO blocks the grant even if a pop is in flight this cycle.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = SrcInst;
    if (!fifo_full) begin
      if (lock_q && owner_req) begin
        gnt_valid = 1'b1;
        gnt       = lock_owner_q;
      end else if (inst_req && data_req) begin
        gnt_valid = 1'b1;
        gnt       = (last_q == SrcInst) ? SrcData : SrcInst;
      end else if (inst_req) begin
        gnt_valid = 1'b1;
        gnt       = SrcInst;
      end else if (data_req) begin
        gnt_valid = 1'b1;
        gnt       = SrcData;
      end
    end
  end

  assign accept = gnt_valid & mem_addr_ok;
  assign pop    = mem_data_ok & ~fifo_empty;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= SrcInst;
      lock_q       <= 1'b0;
      lock_owner_q <= SrcInst;
      own_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      last_q       <= last_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      own_q        <= own_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    last_d       = last_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    own_d        = own_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;

    // Hold the grant on a stalled request so the bus fields stay stable.
    if (gnt_valid && !mem_addr_ok) begin
      lock_d       = 1'b1;
      lock_owner_d = gnt;
    end else if (accept) begin
      lock_d = 1'b0;
    end else if (lock_q && !owner_req) begin
      lock_d = 1'b0;
    end

    if (accept) begin
      own_d[wr_ptr_q] = gnt;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      last_d          = gnt;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Outputs
  always_comb begin
    mem_req   = gnt_valid;
    mem_wr    = inst_wr;
    mem_size  = inst_size;
    mem_addr  = inst_addr;
    mem_wdata = inst_wdata;
    if (gnt_valid && gnt == SrcData) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end

    inst_addr_ok = accept & (gnt == SrcInst);
    data_addr_ok = accept & (gnt == SrcData);
    inst_data_ok = pop & (head == SrcInst);
    data_data_ok = pop & (head == SrcData);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  a_one_addr_ok : assert property (@(posedge clk) disable iff (rst)
    !(inst_addr_ok && data_addr_ok));
  a_cnt_bound : assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CntFull);

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: a reference arbitration model predicts grants
// and pushes expected response owners, which are popped and checked on mem_data_ok.
module tb_sram_like_arbiter;

  localparam int unsigned MaxOut = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic        m_last, m_lock, m_owner;
  logic        exp_q[$];    // expected response owners, 0 = inst, 1 = data
  logic        acc_log[$];  // observed acceptance order from the DUT
  logic [31:0] ia, da;
  logic        obs_mem_req;
  logic [31:0] obs_mem_addr;

  sram_like_arbiter #(.MAX_OUTSTANDING(MaxOut)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_rdata   (inst_rdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] log_bits();
    logic [31:0] v = '0;
    foreach (acc_log[i]) v = (v << 1) | {31'd0, acc_log[i]};
    return v;
  endfunction

  // One bus cycle: drive inputs, check at the falling edge, then advance the model.
  task automatic step(input logic ir, input logic dr, input logic aok, input logic dok,
                      input logic [31:0] rd);
    logic gv, g, e, full;
    inst_req    = ir;
    data_req    = dr;
    inst_addr   = ia;
    data_addr   = da;
    inst_wdata  = ia ^ 32'h1111_1111;
    data_wdata  = da ^ 32'h5A5A_5A5A;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
    @(negedge clk);

    full = (exp_q.size() == MaxOut);
    gv = 1'b0;
    g  = 1'b0;
    if (!full) begin
      if (m_lock && (m_owner ? dr : ir)) begin gv = 1'b1; g = m_owner; end
      else if (ir && dr)                 begin gv = 1'b1; g = ~m_last; end
      else if (ir || dr)                 begin gv = 1'b1; g = dr;      end
    end

    check_eq("mem_req", {31'd0, mem_req}, {31'd0, gv});
    check_eq("mem_addr", mem_addr, (gv && g) ? da : ia);
    if (gv) begin
      check_eq("mem_wdata", mem_wdata, g ? (da ^ 32'h5A5A_5A5A) : (ia ^ 32'h1111_1111));
      check_eq("mem_wr", {31'd0, mem_wr}, {31'd0, g});
    end
    check_eq("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, gv & aok & ~g});
    check_eq("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, gv & aok & g});

    if (dok && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, ~e});
      check_eq("data_data_ok", {31'd0, data_data_ok}, {31'd0, e});
      check_eq("inst_rdata", inst_rdata, rd);
      check_eq("data_rdata", data_rdata, rd);
    end else begin
      check_eq("inst_data_ok_idle", {31'd0, inst_data_ok}, 32'd0);
      check_eq("data_data_ok_idle", {31'd0, data_data_ok}, 32'd0);
    end

    if (inst_addr_ok) acc_log.push_back(1'b0);
    if (data_addr_ok) acc_log.push_back(1'b1);
    obs_mem_req  = mem_req;
    obs_mem_addr = mem_addr;

    if (gv && !aok) begin
      m_lock  = 1'b1;
      m_owner = g;
    end else if (gv && aok) begin
      m_lock = 1'b0;
    end else if (m_lock && !(m_owner ? dr : ir)) begin
      m_lock = 1'b0;
    end
    if (gv && aok) begin
      exp_q.push_back(g);
      m_last = g;
      if (g) da = da + 32'd4;
      else   ia = ia + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    m_last = 1'b0; m_lock = 1'b0; m_owner = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    check_eq("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    ia = 32'hBFC0_0000;
    da = 32'h8000_1000;
    inst_wr = 1'b0; inst_size = 2'd2; data_wr = 1'b1; data_size = 2'd2;
    inst_addr = ia; data_addr = da; inst_wdata = '0; data_wdata = '0; mem_rdata = '0;
    do_reset();

    // Single inst master
    acc_log.delete();
    step(1, 0, 1, 0, 32'h0);
    step(0, 0, 0, 1, 32'h3C08_0000);
    check_eq("single_order", log_bits(), 32'h0);
    check_eq("single_count", acc_log.size(), 1);

    // Tie round-robin from reset: D, I, D, I
    do_reset();
    acc_log.delete();
    repeat (4) step(1, 1, 1, 0, 32'h0);
    check_eq("tie_order", log_bits(), 32'hA);
    repeat (4) step(0, 0, 0, 1, $urandom());

    // Lock while stalled; then an inst lock that overrides the tie rule
    acc_log.delete();
    repeat (3) step(1, 1, 0, 0, 32'h0);
    check_eq("lock_data_addr", obs_mem_addr, da);
    step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    check_eq("lock_order", log_bits(), 32'h2);
    step(1, 0, 0, 0, 32'h0);
    repeat (2) step(1, 1, 0, 0, 32'h0);
    check_eq("lock_hold_inst", obs_mem_addr, ia);
    step(0, 1, 0, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0);
    check_eq("lock_release_order", log_bits(), 32'h5);
    repeat (3) step(0, 0, 0, 1, $urandom());

    // Full FIFO
    acc_log.delete();
    repeat (4) step(1, 0, 1, 0, 32'h0);
    step(1, 0, 1, 0, 32'h0);
    check_eq("full_no_req", {31'd0, obs_mem_req}, 32'd0);
    step(1, 0, 1, 1, $urandom());
    check_eq("full_pop_no_bypass", {31'd0, obs_mem_req}, 32'd0);
    step(1, 0, 1, 0, 32'h0);
    check_eq("full_reassert", {31'd0, obs_mem_req}, 32'd1);
    step(1, 0, 1, 1, $urandom());
    step(1, 0, 1, 1, $urandom());
    check_eq("push_pop_req", {31'd0, obs_mem_req}, 32'd1);
    step(1, 0, 1, 0, 32'h0);
    step(1, 0, 1, 0, 32'h0);
    check_eq("refull_no_req", {31'd0, obs_mem_req}, 32'd0);
    check_eq("full_accepts", acc_log.size(), 7);
    repeat (4) step(0, 0, 0, 1, $urandom());

    // Robustness: stray response, then reset with requests in flight
    step(0, 0, 0, 1, 32'hDEAD_BEEF);
    step(1, 0, 1, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0);
    do_reset();
    repeat (2) step(0, 0, 0, 1, $urandom());
    acc_log.delete();
    step(1, 1, 1, 0, 32'h0);
    check_eq("post_rst_tie", log_bits(), 32'h1);
    step(0, 0, 0, 1, $urandom());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
